// File: rtl/vx_tb_bringup_seq_pkg.sv
// Shared types and default constants for the testbench bring-up sequencer.
package vx_tb_bringup_seq_pkg;

  localparam int VX_DCR_ADDR_WIDTH = 12;
  localparam int VX_DCR_DATA_WIDTH = 32;

  localparam int DEF_NUM_RESETS   = 6;
  localparam int DEF_DLY_W        = 8;
  localparam int DEF_HOLD_CYCLES  = 16;
  localparam int DEF_NUM_DCR      = 4;
  localparam int DEF_LOAD_TIMEOUT = 1024;

  typedef enum logic [2:0] {
    ST_IDLE, ST_HOLD, ST_RELEASE, ST_LOAD, ST_DCR, ST_CORE, ST_DONE, ST_ERROR
  } vx_tb_bringup_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/vx_tb_bringup_seq_if.sv
// Run control, loader handshake, DCR write port and status of the bring-up sequencer.
interface vx_tb_bringup_seq_if;
  import vx_tb_bringup_seq_pkg::*;

  logic                         start;
  logic                         start_mem_loader;
  logic                         mem_loader_done;
  logic                         dcr_write_valid;
  logic [VX_DCR_ADDR_WIDTH-1:0] dcr_write_addr;
  logic [VX_DCR_DATA_WIDTH-1:0] dcr_write_data;
  logic                         busy;
  logic                         done;
  logic                         error;

  modport master (
    input  start, mem_loader_done,
    output start_mem_loader, dcr_write_valid, dcr_write_addr, dcr_write_data,
           busy, done, error
  );

  modport slave (
    output start, mem_loader_done,
    input  start_mem_loader, dcr_write_valid, dcr_write_addr, dcr_write_data,
           busy, done, error
  );
endinterface

// File: rtl/vx_tb_dcr_burst.sv
// Writes table entries 0..count-1 on consecutive cycles; done is high with the last write.
module vx_tb_dcr_burst
  import vx_tb_bringup_seq_pkg::*;
#(
  parameter int  NUM_DCR = DEF_NUM_DCR,
  localparam int CNT_W   = $clog2(NUM_DCR + 1),
  localparam int IDX_W   = (NUM_DCR > 1) ? $clog2(NUM_DCR) : 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [CNT_W-1:0]                     count,
  input  logic [NUM_DCR*VX_DCR_ADDR_WIDTH-1:0] addr_tbl,
  input  logic [NUM_DCR*VX_DCR_DATA_WIDTH-1:0] data_tbl,
  output logic                                 valid,
  output logic [VX_DCR_ADDR_WIDTH-1:0]         addr,
  output logic [VX_DCR_DATA_WIDTH-1:0]         data,
  output logic                                 done
);
  logic [VX_DCR_ADDR_WIDTH-1:0] addr_arr [NUM_DCR];
  logic [VX_DCR_DATA_WIDTH-1:0] data_arr [NUM_DCR];
  logic [IDX_W-1:0]             idx_q;
  logic [CNT_W-1:0]             left_q;

  for (genvar i = 0; i < NUM_DCR; i++) begin : g_tbl
    assign addr_arr[i] = addr_tbl[i*VX_DCR_ADDR_WIDTH +: VX_DCR_ADDR_WIDTH];
    assign data_arr[i] = data_tbl[i*VX_DCR_DATA_WIDTH +: VX_DCR_DATA_WIDTH];
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid  <= 1'b0;
      addr   <= '0;
      data   <= '0;
      done   <= 1'b0;
      idx_q  <= '0;
      left_q <= '0;
    end else if (start && count != '0) begin
      valid  <= 1'b1;
      addr   <= addr_arr[0];
      data   <= data_arr[0];
      idx_q  <= IDX_W'(1);
      left_q <= count - CNT_W'(1);
      done   <= (count == CNT_W'(1));
    end else if (valid && left_q != '0) begin
      addr   <= addr_arr[idx_q];
      data   <= data_arr[idx_q];
      idx_q  <= idx_q + IDX_W'(1);
      left_q <= left_q - CNT_W'(1);
      done   <= (left_q == CNT_W'(1));
    end else begin
      // Bus returns to zero after the burst so no stale address lingers.
      valid  <= 1'b0;
      addr   <= '0;
      data   <= '0;
      done   <= 1'b0;
      idx_q  <= '0;
      left_q <= '0;
    end
  end
endmodule

// File: rtl/vx_tb_bringup_seq.sv
// Bring-up sequencer: hold, staggered reset release, optional memory load, DCR burst, core release.
module vx_tb_bringup_seq
  import vx_tb_bringup_seq_pkg::*;
#(
  parameter int  NUM_RESETS   = DEF_NUM_RESETS,
  parameter int  DLY_W        = DEF_DLY_W,
  parameter int  HOLD_CYCLES  = DEF_HOLD_CYCLES,
  parameter int  NUM_DCR      = DEF_NUM_DCR,
  parameter int  LOAD_TIMEOUT = DEF_LOAD_TIMEOUT,
  localparam int DCR_CNT_W    = $clog2(NUM_DCR + 1)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_RESETS*DLY_W-1:0]          rst_dly,
  input  logic                                 load_en,
  input  logic [DCR_CNT_W-1:0]                 dcr_count,
  input  logic [NUM_DCR*VX_DCR_ADDR_WIDTH-1:0] dcr_addr_tbl,
  input  logic [NUM_DCR*VX_DCR_DATA_WIDTH-1:0] dcr_data_tbl,
  output logic [NUM_RESETS-1:0]                rst_out,
  output logic                                 core_reset,
  vx_tb_bringup_seq_if.master                  bus
);
  localparam int TO_W = $clog2(LOAD_TIMEOUT + 1);
  localparam int PH_W = max_int(DLY_W, $clog2(HOLD_CYCLES + 1));

  vx_tb_bringup_state_e state_q, state_d, after_mem;
  logic [PH_W-1:0]       phase_q, phase_d;
  logic [TO_W-1:0]       load_cnt_q, load_cnt_d;
  logic [NUM_RESETS-1:0] rst_out_q, rst_out_d, rel_mask;
  logic                  core_reset_q, sml_q, busy_q, done_q, error_q;
  logic                  start_accept, burst_start, burst_done;

  logic [NUM_RESETS*DLY_W-1:0]          dly_q;
  logic                                 load_en_q;
  logic [DCR_CNT_W-1:0]                 dcr_cnt_q;
  logic [NUM_DCR*VX_DCR_ADDR_WIDTH-1:0] addr_tbl_q;
  logic [NUM_DCR*VX_DCR_DATA_WIDTH-1:0] data_tbl_q;

  assign start_accept = bus.start && (state_q inside {ST_IDLE, ST_DONE, ST_ERROR});
  assign burst_start  = (state_d == ST_DCR) && (state_q != ST_DCR);

  // NOTE: run configuration is plain storage with no reset; it is only read after start loads it.
  always_ff @(posedge clk) begin
    if (start_accept) begin
      dly_q      <= rst_dly;
      load_en_q  <= load_en;
      dcr_cnt_q  <= (dcr_count > DCR_CNT_W'(NUM_DCR)) ? DCR_CNT_W'(NUM_DCR) : dcr_count;
      addr_tbl_q <= dcr_addr_tbl;
      data_tbl_q <= dcr_data_tbl;
    end
  end

  // NOTE: every always_comb output is given a default first so no latch can be inferred.
  always_comb begin
    after_mem  = (dcr_cnt_q != '0) ? ST_DCR : ST_CORE;
    state_d    = state_q;
    phase_d    = '0;
    load_cnt_d = '0;
    rel_mask   = '0;
    rst_out_d  = '1;

    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: if (bus.start) state_d = ST_HOLD;
      ST_HOLD:    if (phase_q == PH_W'(HOLD_CYCLES - 1)) state_d = ST_RELEASE;
      ST_RELEASE: if (rst_out_q == '0) state_d = load_en_q ? ST_LOAD : after_mem;
      ST_LOAD: begin
        // The pulse cycle itself (count 0) never samples the loader; done beats timeout.
        if (load_cnt_q != '0 && bus.mem_loader_done) state_d = after_mem;
        else if (load_cnt_q == TO_W'(LOAD_TIMEOUT - 1)) state_d = ST_ERROR;
      end
      ST_DCR:  if (burst_done) state_d = ST_CORE;
      ST_CORE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase

    if (state_d == state_q && state_q inside {ST_HOLD, ST_RELEASE})
      phase_d = phase_q + PH_W'(1);
    if (state_d == ST_LOAD && state_q == ST_LOAD)
      load_cnt_d = load_cnt_q + TO_W'(1);

    for (int i = 0; i < NUM_RESETS; i++)
      rel_mask[i] = (phase_d >= PH_W'(dly_q[i*DLY_W +: DLY_W]));

    unique case (state_d)
      ST_RELEASE:                        rst_out_d = rst_out_q & ~rel_mask;
      ST_LOAD, ST_DCR, ST_CORE, ST_DONE: rst_out_d = '0;
      default:                           rst_out_d = '1;
    endcase
  end

  // Outputs are registered from the next state so each lines up with the cycle it describes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      phase_q      <= '0;
      load_cnt_q   <= '0;
      rst_out_q    <= '1;
      core_reset_q <= 1'b1;
      sml_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      load_cnt_q   <= load_cnt_d;
      rst_out_q    <= rst_out_d;
      core_reset_q <= !(state_d inside {ST_CORE, ST_DONE});
      sml_q        <= (state_d == ST_LOAD) && (state_q != ST_LOAD);
      busy_q       <= state_d inside {ST_HOLD, ST_RELEASE, ST_LOAD, ST_DCR, ST_CORE};
      done_q       <= (state_d == ST_DONE);
      error_q      <= (state_d == ST_ERROR);
    end
  end

  logic                         wr_valid;
  logic [VX_DCR_ADDR_WIDTH-1:0] wr_addr;
  logic [VX_DCR_DATA_WIDTH-1:0] wr_data;

  vx_tb_dcr_burst #(.NUM_DCR(NUM_DCR)) u_burst (
    .clk      (clk),
    .reset    (reset),
    .start    (burst_start),
    .count    (dcr_cnt_q),
    .addr_tbl (addr_tbl_q),
    .data_tbl (data_tbl_q),
    .valid    (wr_valid),
    .addr     (wr_addr),
    .data     (wr_data),
    .done     (burst_done)
  );

  assign rst_out              = rst_out_q;
  assign core_reset           = core_reset_q;
  assign bus.start_mem_loader = sml_q;
  assign bus.dcr_write_valid  = wr_valid;
  assign bus.dcr_write_addr   = wr_addr;
  assign bus.dcr_write_data   = wr_data;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.error            = error_q;
endmodule

// File: tb/tb_vx_tb_bringup_seq.sv
// Directed bench for the bring-up sequencer: staging, loader handshake, timeout, DCR burst, reset.
module tb_vx_tb_bringup_seq;
  import vx_tb_bringup_seq_pkg::*;

  localparam int NUM_RESETS   = 6;
  localparam int DLY_W        = 8;
  localparam int HOLD_CYCLES  = 4;
  localparam int NUM_DCR      = 4;
  localparam int LOAD_TIMEOUT = 32;
  localparam int DCR_CNT_W    = $clog2(NUM_DCR + 1);
  localparam int AW           = VX_DCR_ADDR_WIDTH;
  localparam int DW           = VX_DCR_DATA_WIDTH;

  logic                        clk = 1'b0;
  logic                        reset;
  logic [NUM_RESETS*DLY_W-1:0] rst_dly;
  logic                        load_en;
  logic [DCR_CNT_W-1:0]        dcr_count;
  logic [NUM_DCR*AW-1:0]       dcr_addr_tbl;
  logic [NUM_DCR*DW-1:0]       dcr_data_tbl;
  logic [NUM_RESETS-1:0]       rst_out;
  logic                        core_reset;

  vx_tb_bringup_seq_if bus();

  vx_tb_bringup_seq #(
    .NUM_RESETS(NUM_RESETS), .DLY_W(DLY_W), .HOLD_CYCLES(HOLD_CYCLES),
    .NUM_DCR(NUM_DCR), .LOAD_TIMEOUT(LOAD_TIMEOUT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rst_dly      (rst_dly),
    .load_en      (load_en),
    .dcr_count    (dcr_count),
    .dcr_addr_tbl (dcr_addr_tbl),
    .dcr_data_tbl (dcr_data_tbl),
    .rst_out      (rst_out),
    .core_reset   (core_reset),
    .bus          (bus.master)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int sml_cnt = 0;
  int wr_cnt = 0;
  logic [AW-1:0] wr_addr_q[$];
  logic [DW-1:0] wr_data_q[$];

  always @(negedge clk) begin
    if (bus.start_mem_loader === 1'b1) sml_cnt++;
    if (bus.dcr_write_valid === 1'b1) begin
      wr_cnt++;
      wr_addr_q.push_back(bus.dcr_write_addr);
      wr_data_q.push_back(bus.dcr_write_data);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic clear_mon();
    sml_cnt = 0;
    wr_cnt  = 0;
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  task automatic set_dly(input int base, input int inc);
    for (int i = 0; i < NUM_RESETS; i++)
      rst_dly[i*DLY_W +: DLY_W] = DLY_W'(base + inc * i);
  endtask

  task automatic set_tbl(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    dcr_addr_tbl[i*AW +: AW] = a;
    dcr_data_tbl[i*DW +: DW] = d;
  endtask

  task automatic default_tbl();
    set_tbl(0, 12'h001, 32'hA);
    set_tbl(1, 12'h002, 32'hB);
    set_tbl(2, 12'h003, 32'hC);
    set_tbl(3, 12'h004, 32'hD);
  endtask

  task automatic test_reset();
    logic [NUM_RESETS+AW+DW+6:0] got, want;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.mem_loader_done = 1'b0;
    set_dly(0, 0);
    load_en = 1'b0;
    dcr_count = '0;
    default_tbl();
    step();
    step();
    got  = {rst_out, core_reset, bus.start_mem_loader, bus.dcr_write_valid,
            bus.dcr_write_addr, bus.dcr_write_data, bus.busy, bus.done, bus.error};
    want = {{NUM_RESETS{1'b1}}, 1'b1, 1'b0, 1'b0, {AW{1'b0}}, {DW{1'b0}}, 3'b000};
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL reset_values got=%h want=%h", got, want);
    end
    reset = 1'b0;
    step();
    step();
    n_cmp++;
    if ({bus.busy, core_reset, rst_out} !== {1'b0, 1'b1, {NUM_RESETS{1'b1}}}) begin
      n_bad++;
      $display("FAIL idle_after_reset busy=%b core_reset=%b rst_out=%b", bus.busy, core_reset, rst_out);
    end
  endtask

  task automatic test_stagger();
    set_dly(0, 2);
    load_en = 1'b0;
    dcr_count = '0;
    clear_mon();
    do_start();
    for (int h = 0; h < HOLD_CYCLES; h++) begin
      n_cmp++;
      if ({bus.busy, core_reset, rst_out} !== {1'b1, 1'b1, {NUM_RESETS{1'b1}}}) begin
        n_bad++;
        $display("FAIL stagger_hold h=%0d busy=%b core_reset=%b rst_out=%b", h, bus.busy, core_reset, rst_out);
      end
      step();
    end
    for (int k = 0; k <= 12; k++) begin
      logic [NUM_RESETS-1:0] exp_rst;
      logic exp_core, exp_done;
      for (int i = 0; i < NUM_RESETS; i++) exp_rst[i] = (k < 2 * i);
      exp_core = (k <= 10);
      exp_done = (k >= 12);
      n_cmp++;
      if (rst_out !== exp_rst) begin
        n_bad++;
        $display("FAIL stagger_rst k=%0d got=%b want=%b", k, rst_out, exp_rst);
      end
      n_cmp++;
      if (core_reset !== exp_core) begin
        n_bad++;
        $display("FAIL stagger_core k=%0d got=%b want=%b", k, core_reset, exp_core);
      end
      n_cmp++;
      if (bus.done !== exp_done) begin
        n_bad++;
        $display("FAIL stagger_done k=%0d got=%b want=%b", k, bus.done, exp_done);
      end
      step();
    end
    n_cmp++;
    if (sml_cnt !== 0 || wr_cnt !== 0) begin
      n_bad++;
      $display("FAIL stagger_side pulses=%0d writes=%0d want 0/0", sml_cnt, wr_cnt);
    end
  endtask

  task automatic test_load();
    set_dly(0, 0);
    load_en = 1'b1;
    dcr_count = '0;
    do_start();
    clear_mon();
    repeat (HOLD_CYCLES) step();
    n_cmp++;
    if (rst_out !== '0) begin
      n_bad++;
      $display("FAIL load_release got=%b want=0", rst_out);
    end
    step();
    n_cmp++;
    if (bus.start_mem_loader !== 1'b1) begin
      n_bad++;
      $display("FAIL load_pulse got=%b want=1", bus.start_mem_loader);
    end
    bus.mem_loader_done = 1'b1;
    step();
    bus.mem_loader_done = 1'b0;
    for (int j = 1; j <= 5; j++) begin
      n_cmp++;
      if ({bus.busy, core_reset, bus.start_mem_loader} !== 3'b110) begin
        n_bad++;
        $display("FAIL load_wait j=%0d busy=%b core_reset=%b pulse=%b want 1/1/0",
                 j, bus.busy, core_reset, bus.start_mem_loader);
      end
      if (j == 5) bus.mem_loader_done = 1'b1;
      step();
    end
    bus.mem_loader_done = 1'b0;
    n_cmp++;
    if ({core_reset, bus.error} !== 2'b00) begin
      n_bad++;
      $display("FAIL load_core core_reset=%b error=%b want 0/0", core_reset, bus.error);
    end
    step();
    n_cmp++;
    if (bus.done !== 1'b1 || sml_cnt !== 1) begin
      n_bad++;
      $display("FAIL load_done done=%b pulses=%0d want 1/1", bus.done, sml_cnt);
    end
  endtask

  task automatic test_timeout();
    logic [NUM_RESETS+4:0] got, want;
    set_dly(0, 0);
    load_en = 1'b1;
    dcr_count = DCR_CNT_W'(3);
    bus.mem_loader_done = 1'b0;
    do_start();
    clear_mon();
    repeat (HOLD_CYCLES + 1) step();
    for (int j = 0; j < LOAD_TIMEOUT; j++) begin
      n_cmp++;
      if ({bus.error, bus.busy} !== 2'b01) begin
        n_bad++;
        $display("FAIL timeout_wait j=%0d error=%b busy=%b want 0/1", j, bus.error, bus.busy);
      end
      step();
    end
    got  = {bus.error, rst_out, core_reset, bus.busy, bus.done, bus.dcr_write_valid};
    want = {1'b1, {NUM_RESETS{1'b1}}, 1'b1, 1'b0, 1'b0, 1'b0};
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL timeout_error got=%b want=%b", got, want);
    end
    repeat (3) step();
    n_cmp++;
    if (bus.error !== 1'b1 || wr_cnt !== 0 || sml_cnt !== 1) begin
      n_bad++;
      $display("FAIL timeout_hold error=%b writes=%0d pulses=%0d want 1/0/1", bus.error, wr_cnt, sml_cnt);
    end
  endtask

  task automatic run_dcr(input string name, input int cnt_in, input int n_wr);
    set_dly(0, 0);
    load_en = 1'b0;
    dcr_count = DCR_CNT_W'(cnt_in);
    default_tbl();
    do_start();
    clear_mon();
    repeat (HOLD_CYCLES) step();
    n_cmp++;
    if ({bus.error, rst_out} !== '0) begin
      n_bad++;
      $display("FAIL %s_release error=%b rst_out=%b want 0", name, bus.error, rst_out);
    end
    step();
    for (int j = 0; j < n_wr; j++) begin
      n_cmp++;
      if ({bus.dcr_write_valid, core_reset, bus.dcr_write_addr, bus.dcr_write_data} !==
          {1'b1, 1'b1, AW'(j + 1), DW'(10 + j)}) begin
        n_bad++;
        $display("FAIL %s_write j=%0d valid=%b core_reset=%b addr=%h data=%h want 1/1/%h/%h", name, j,
                 bus.dcr_write_valid, core_reset, bus.dcr_write_addr, bus.dcr_write_data, j + 1, 10 + j);
      end
      step();
    end
    n_cmp++;
    if ({bus.dcr_write_valid, core_reset} !== 2'b00) begin
      n_bad++;
      $display("FAIL %s_core valid=%b core_reset=%b want 0/0", name, bus.dcr_write_valid, core_reset);
    end
    step();
    n_cmp++;
    if (bus.done !== 1'b1 || wr_cnt !== n_wr) begin
      n_bad++;
      $display("FAIL %s_done done=%b writes=%0d want 1/%0d", name, bus.done, wr_cnt, n_wr);
    end
  endtask

  task automatic test_dcr();
    run_dcr("dcr3", 3, 3);
  endtask

  task automatic test_clamp();
    run_dcr("clamp", 7, NUM_DCR);
  endtask

  task automatic test_config_latch();
    set_dly(3, 0);
    load_en = 1'b0;
    dcr_count = DCR_CNT_W'(1);
    set_tbl(0, 12'h055, 32'h1234_5678);
    do_start();
    clear_mon();
    set_dly(0, 0);
    load_en = 1'b1;
    dcr_count = DCR_CNT_W'(4);
    set_tbl(0, 12'h0AA, 32'h8765_4321);
    repeat (HOLD_CYCLES) step();
    for (int k = 0; k < 4; k++) begin
      logic [NUM_RESETS-1:0] exp_rst;
      exp_rst = (k < 3) ? '1 : '0;
      n_cmp++;
      if (rst_out !== exp_rst) begin
        n_bad++;
        $display("FAIL latch_rst k=%0d got=%b want=%b", k, rst_out, exp_rst);
      end
      step();
    end
    n_cmp++;
    if ({bus.dcr_write_valid, bus.dcr_write_addr, bus.dcr_write_data} !== {1'b1, 12'h055, 32'h1234_5678}) begin
      n_bad++;
      $display("FAIL latch_write valid=%b addr=%h data=%h want 1/055/12345678",
               bus.dcr_write_valid, bus.dcr_write_addr, bus.dcr_write_data);
    end
    step();
    n_cmp++;
    if ({bus.dcr_write_valid, core_reset} !== 2'b00) begin
      n_bad++;
      $display("FAIL latch_core valid=%b core_reset=%b want 0/0", bus.dcr_write_valid, core_reset);
    end
    step();
    n_cmp++;
    if (bus.done !== 1'b1 || sml_cnt !== 0 || wr_cnt !== 1) begin
      n_bad++;
      $display("FAIL latch_done done=%b pulses=%0d writes=%0d want 1/0/1", bus.done, sml_cnt, wr_cnt);
    end
  endtask

  task automatic test_busy_reset();
    logic [NUM_RESETS+AW+DW+6:0] got, want;
    set_dly(0, 0);
    load_en = 1'b0;
    dcr_count = DCR_CNT_W'(4);
    default_tbl();
    do_start();
    clear_mon();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    n_cmp++;
    if (rst_out !== '1) begin
      n_bad++;
      $display("FAIL busy_hold got=%b want all ones", rst_out);
    end
    step();
    n_cmp++;
    if (rst_out !== '0) begin
      n_bad++;
      $display("FAIL busy_release got=%b want 0", rst_out);
    end
    bus.start = 1'b1;
    step();
    n_cmp++;
    if ({bus.dcr_write_valid, bus.dcr_write_addr} !== {1'b1, 12'h001}) begin
      n_bad++;
      $display("FAIL busy_first valid=%b addr=%h want 1/001", bus.dcr_write_valid, bus.dcr_write_addr);
    end
    step();
    bus.start = 1'b0;
    n_cmp++;
    if ({bus.dcr_write_valid, bus.dcr_write_addr, rst_out} !== {1'b1, 12'h002, {NUM_RESETS{1'b0}}}) begin
      n_bad++;
      $display("FAIL busy_second valid=%b addr=%h rst_out=%b want 1/002/0",
               bus.dcr_write_valid, bus.dcr_write_addr, rst_out);
    end
    reset = 1'b1;
    step();
    got  = {rst_out, core_reset, bus.start_mem_loader, bus.dcr_write_valid,
            bus.dcr_write_addr, bus.dcr_write_data, bus.busy, bus.done, bus.error};
    want = {{NUM_RESETS{1'b1}}, 1'b1, 1'b0, 1'b0, {AW{1'b0}}, {DW{1'b0}}, 3'b000};
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL midrun_reset got=%h want=%h", got, want);
    end
    reset = 1'b0;
    repeat (4) step();
    n_cmp++;
    if (wr_cnt !== 2 || bus.busy !== 1'b0 || bus.dcr_write_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL after_reset writes=%0d busy=%b valid=%b want 2/0/0", wr_cnt, bus.busy, bus.dcr_write_valid);
    end
  endtask

  initial begin
    test_reset();
    test_stagger();
    test_load();
    test_timeout();
    test_dcr();
    test_clamp();
    test_config_latch();
    test_busy_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
